// File: rtl/hazard_control_unit_if.sv
// Pipeline-to-hazard-unit bundle: stage register fields in, stall/flush/forward controls out.
// The pipeline side uses the master modport; the hazard unit uses the slave modport.
interface hazard_control_unit_if;
  logic [4:0]  RS1_D, RS2_D;
  logic [4:0]  RS1_E, RS2_E;
  logic [4:0]  RD_E, RD_M, RD_W;
  logic        REG_W_En_M, REG_W_En_W;
  logic [1:0]  Result_Src_Sel_E;
  logic        PC_Src_Sel_E;
  logic        MEM_Access_M;
  logic        MEM_Ready_M;
  logic        Stall_F, Stall_D;
  logic        Flush_D, Flush_E;
  logic        Stall_E, Stall_M;
  logic        Flush_W;
  logic [1:0]  Forward_A_E, Forward_B_E;
  logic        MEM_Timeout_Err;
  logic [31:0] Stall_Count, Flush_Count;

  modport master (
    output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W,
           REG_W_En_M, REG_W_En_W, Result_Src_Sel_E, PC_Src_Sel_E,
           MEM_Access_M, MEM_Ready_M,
    input  Stall_F, Stall_D, Flush_D, Flush_E, Stall_E, Stall_M, Flush_W,
           Forward_A_E, Forward_B_E, MEM_Timeout_Err, Stall_Count, Flush_Count
  );

  modport slave (
    input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W,
           REG_W_En_M, REG_W_En_W, Result_Src_Sel_E, PC_Src_Sel_E,
           MEM_Access_M, MEM_Ready_M,
    output Stall_F, Stall_D, Flush_D, Flush_E, Stall_E, Stall_M, Flush_W,
           Forward_A_E, Forward_B_E, MEM_Timeout_Err, Stall_Count, Flush_Count
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Stall/flush/forward control for the 5-stage pipeline registers (INIT/RUN/MEM_WAIT FSM).
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_control_unit #(
  parameter int RESET_FLUSH_CYCLES = 4,
  parameter int MEM_TIMEOUT        = 16
) (
  input logic CLK,
  input logic RST,
  hazard_control_unit_if.slave hz
);

  localparam int FW = $clog2(RESET_FLUSH_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(RESET_FLUSH_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} state_t;

  state_t        state;
  logic [FW-1:0] flush_cnt;
  logic [WW-1:0] wait_cnt;
  logic          timeout_err;

  logic stall_f, stall_d, flush_d, flush_e, stall_e, stall_m, flush_w;
  logic load_use, mem_block, timeout_hit;

  // Writers in M take precedence over W; x0 is hard-wired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic en_m, input logic [4:0] rd_m,
                                         input logic en_w, input logic [4:0] rd_w);
    if (en_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (en_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign load_use    = (hz.Result_Src_Sel_E == 2'b01) && (hz.RD_E != 5'd0) &&
                       ((hz.RD_E == hz.RS1_D) || (hz.RD_E == hz.RS2_D));
  assign mem_block   = hz.MEM_Access_M && !hz.MEM_Ready_M;
  assign timeout_hit = (state == MEM_WAIT) && !hz.MEM_Ready_M && (wait_cnt == WAIT_LIMIT);

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_w = 1'b0;
    if (RST || (state == INIT)) begin
      stall_f = 1'b1;
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if ((state == MEM_WAIT) && !hz.MEM_Ready_M && !timeout_hit) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if ((state == RUN) || (state == MEM_WAIT)) begin
      // A ready or abandoned wait releases the pipe and re-evaluates hazards like RUN.
      if ((state == RUN) && mem_block) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (hz.PC_Src_Sel_E) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      if (timeout_hit)
        flush_w = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= INIT;
      flush_cnt   <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (flush_cnt == FLUSH_LAST) begin
            state     <= RUN;
            flush_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        RUN: begin
          if (mem_block) begin
            state    <= MEM_WAIT;
            wait_cnt <= WW'(1);
          end
        end
        MEM_WAIT: begin
          if (hz.MEM_Ready_M) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state       <= RUN;
            wait_cnt    <= '0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count, flush_count;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (((state == RUN) || (state == MEM_WAIT)) && stall_f)
        stall_count <= sat_inc(stall_count);
      if ((state == RUN) && flush_e)
        flush_count <= sat_inc(flush_count);
    end
  end

  assign hz.Stall_Count = stall_count;
  assign hz.Flush_Count = flush_count;
`else
  assign hz.Stall_Count = 32'h0;
  assign hz.Flush_Count = 32'h0;
`endif

  assign hz.Stall_F         = stall_f;
  assign hz.Stall_D         = stall_d;
  assign hz.Flush_D         = flush_d;
  assign hz.Flush_E         = flush_e;
  assign hz.Stall_E         = stall_e;
  assign hz.Stall_M         = stall_m;
  assign hz.Flush_W         = flush_w;
  assign hz.MEM_Timeout_Err = timeout_err;
  assign hz.Forward_A_E     = fwd_sel(hz.RS1_E, hz.REG_W_En_M, hz.RD_M, hz.REG_W_En_W, hz.RD_W);
  assign hz.Forward_B_E     = fwd_sel(hz.RS2_E, hz.REG_W_En_M, hz.RD_M, hz.REG_W_En_W, hz.RD_W);

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: reset flush, load-use, redirect, forwarding,
// memory wait release and timeout, counters when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_control_unit;

  logic CLK = 1'b0;
  logic RST;

  hazard_control_unit_if hz ();

  hazard_control_unit #(
    .RESET_FLUSH_CYCLES(4),
    .MEM_TIMEOUT(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .hz(hz)
  );

  always #5 CLK = ~CLK;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {Stall_F, Stall_D, Flush_D, Flush_E, Stall_E, Stall_M, Flush_W}
  localparam logic [6:0] P_INIT = 7'b1011001;
  localparam logic [6:0] P_LU   = 7'b1101000;
  localparam logic [6:0] P_BR   = 7'b0011000;
  localparam logic [6:0] P_MEM  = 7'b1100111;
  localparam logic [6:0] P_TO   = 7'b0000001;
  localparam logic [6:0] P_NONE = 7'b0000000;

  logic [6:0] ctl;
  assign ctl = {hz.Stall_F, hz.Stall_D, hz.Flush_D, hz.Flush_E, hz.Stall_E, hz.Stall_M, hz.Flush_W};

  int n_checks = 0;
  int n_fail   = 0;
  int exp_sc   = 0;
  int exp_fc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_stall_cnt"}, hz.Stall_Count, PERF ? 32'(exp_sc) : 32'h0);
    chk({tag, "_flush_cnt"}, hz.Flush_Count, PERF ? 32'(exp_fc) : 32'h0);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    hz.RS1_D = 5'd0; hz.RS2_D = 5'd0;
    hz.RS1_E = 5'd0; hz.RS2_E = 5'd0;
    hz.RD_E = 5'd0;  hz.RD_M = 5'd0; hz.RD_W = 5'd0;
    hz.REG_W_En_M = 1'b0; hz.REG_W_En_W = 1'b0;
    hz.Result_Src_Sel_E = 2'b00;
    hz.PC_Src_Sel_E = 1'b0;
    hz.MEM_Access_M = 1'b0;
    hz.MEM_Ready_M = 1'b1;
  endtask

  initial begin
    // Reset held for three edges, then four forced-flush cycles
    RST = 1'b1;
    idle_inputs();
    #1;
    chk("rst_ctl", 32'(ctl), 32'(P_INIT));
    chk("rst_fwd", 32'({hz.Forward_A_E, hz.Forward_B_E}), 32'h0);
    repeat (3) cyc();
    chk("rst_err", 32'(hz.MEM_Timeout_Err), 32'h0);
    chk_cnt("rst");
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("init_ctl", 32'(ctl), 32'(P_INIT));
      cyc();
    end
    #1;
    chk("run_idle", 32'(ctl), 32'(P_NONE));
    cyc();

    // Load-use on RS2_D, then same with RD_E = x0
    hz.RD_E = 5'd5; hz.Result_Src_Sel_E = 2'b01; hz.RS2_D = 5'd5;
    #1;
    chk("load_use", 32'(ctl), 32'(P_LU));
    exp_sc++; exp_fc++;
    cyc();
    hz.RD_E = 5'd0;
    #1;
    chk("load_use_x0", 32'(ctl), 32'(P_NONE));
    cyc();

    // Redirect overrides load-use in the same cycle
    hz.RD_E = 5'd5; hz.PC_Src_Sel_E = 1'b1;
    #1;
    chk("branch_over_lu", 32'(ctl), 32'(P_BR));
    exp_fc++;
    cyc();
    idle_inputs();

    // Forwarding priority and x0 suppression
    hz.RS1_E = 5'd7; hz.RS2_E = 5'd3; hz.RD_M = 5'd7; hz.RD_W = 5'd7;
    hz.REG_W_En_M = 1'b1; hz.REG_W_En_W = 1'b1;
    #1;
    chk("fwd_a_m", 32'(hz.Forward_A_E), 32'h2);
    chk("fwd_b_none", 32'(hz.Forward_B_E), 32'h0);
    hz.REG_W_En_M = 1'b0;
    #1;
    chk("fwd_a_w", 32'(hz.Forward_A_E), 32'h1);
    hz.REG_W_En_M = 1'b1; hz.RD_M = 5'd0; hz.RD_W = 5'd0;
    #1;
    chk("fwd_a_rd0", 32'(hz.Forward_A_E), 32'h0);
    hz.RS1_E = 5'd0; hz.RS2_E = 5'd9; hz.RD_W = 5'd9;
    #1;
    chk("fwd_x0_a", 32'(hz.Forward_A_E), 32'h0);
    chk("fwd_b_w", 32'(hz.Forward_B_E), 32'h1);
    chk("fwd_ctl", 32'(ctl), 32'(P_NONE));
    cyc();
    idle_inputs();

    // Three memory wait cycles then ready; a redirect during the wait is held off
    hz.MEM_Access_M = 1'b1; hz.MEM_Ready_M = 1'b0;
    #1;
    chk("mem_stall_run", 32'(ctl), 32'(P_MEM));
    exp_sc++;
    cyc();
    hz.PC_Src_Sel_E = 1'b1;
    #1;
    chk("mem_wait_br", 32'(ctl), 32'(P_MEM));
    exp_sc++;
    cyc();
    hz.PC_Src_Sel_E = 1'b0;
    #1;
    chk("mem_wait_2", 32'(ctl), 32'(P_MEM));
    exp_sc++;
    cyc();
    hz.MEM_Ready_M = 1'b1;
    #1;
    chk("mem_release", 32'(ctl), 32'(P_NONE));
    chk("mem_release_err", 32'(hz.MEM_Timeout_Err), 32'h0);
    cyc();
    hz.MEM_Access_M = 1'b0;
    #1;
    chk("mem_after", 32'(ctl), 32'(P_NONE));
    chk_cnt("mem");

    // Reset in the middle of a memory wait
    hz.MEM_Access_M = 1'b1; hz.MEM_Ready_M = 1'b0;
    #1;
    exp_sc++;
    cyc();
    exp_sc++;
    cyc();
    chk("pre_rst_wait", 32'(ctl), 32'(P_MEM));
    chk_cnt("pre_rst");
    RST = 1'b1;
    #1;
    chk("rst_mid_wait", 32'(ctl), 32'(P_INIT));
    cyc();
    RST = 1'b0;
    idle_inputs();
    exp_sc = 0; exp_fc = 0;
    chk_cnt("post_rst");
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("reinit_ctl", 32'(ctl), 32'(P_INIT));
      cyc();
    end
    #1;
    chk("rerun_idle", 32'(ctl), 32'(P_NONE));
    chk_cnt("reinit");

    // Memory never ready: timeout after 16 stalled cycles
    hz.MEM_Access_M = 1'b1; hz.MEM_Ready_M = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("to_stall", 32'(ctl), 32'(P_MEM));
      cyc();
    end
    exp_sc = 16;
    #1;
    chk("to_release", 32'(ctl), 32'(P_TO));
    chk("to_err_pre", 32'(hz.MEM_Timeout_Err), 32'h0);
    cyc();
    hz.MEM_Access_M = 1'b0; hz.MEM_Ready_M = 1'b1;
    #1;
    chk("to_err", 32'(hz.MEM_Timeout_Err), 32'h1);
    chk("to_after", 32'(ctl), 32'(P_NONE));
    chk_cnt("to");
    repeat (3) cyc();
    chk("to_err_sticky", 32'(hz.MEM_Timeout_Err), 32'h1);
    RST = 1'b1;
    cyc();
    chk("to_err_clr", 32'(hz.MEM_Timeout_Err), 32'h0);
    RST = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
